// File: rtl/clk_div_gen_multi_if.sv
// Bus bundle for clk_div_gen_multi.
// Defines the ratio request, handshake, divided clocks, strobes and lock status.
//   div_i      : requested ratios; channel k uses bits [k*CNT_W +: CNT_W]
//   div_load_i : single-cycle load request
//   div_busy_o : ratio update in progress
//   clk_o      : divided clocks, one per channel
//   clk_en_o   : one-cycle strobe per divided period
//   locked_o   : all channels stable at their current ratios
//   clk_gate_i : per-channel output gate (only when CLKDIV_GATE_EN is defined)
// The master modport is the requester/consumer; the slave modport is the divider.
interface clk_div_gen_multi_if #(
  parameter int unsigned NUM_CLK = 2,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_CLK*CNT_W-1:0] div_i;
  logic                     div_load_i;
  logic                     div_busy_o;
  logic [NUM_CLK-1:0]       clk_o;
  logic [NUM_CLK-1:0]       clk_en_o;
  logic                     locked_o;
`ifdef CLKDIV_GATE_EN
  logic [NUM_CLK-1:0]       clk_gate_i;

  modport master (
    output div_i, div_load_i, clk_gate_i,
    input  div_busy_o, clk_o, clk_en_o, locked_o
  );
  modport slave (
    input  div_i, div_load_i, clk_gate_i,
    output div_busy_o, clk_o, clk_en_o, locked_o
  );
`else
  modport master (
    output div_i, div_load_i,
    input  div_busy_o, clk_o, clk_en_o, locked_o
  );
  modport slave (
    input  div_i, div_load_i,
    output div_busy_o, clk_o, clk_en_o, locked_o
  );
`endif
endinterface

// File: rtl/clk_div_gen_multi.sv
// Multi-channel clock divider and lock generator.
// Produces NUM_CLK divided clocks and per-period enable strobes from board_clk_i.
// Each channel's ratio can be reprogrammed at runtime. A new ratio is adopted
// only at that channel's own wrap edge, so the output never shows a runt pulse.
// Ports:
//   board_clk_i : reference clock (all flops on its rising edge)
//   RESETn_i    : asynchronous active-low reset
//   bus         : clk_div_gen_multi_if slave (ratio load handshake, clk_o,
//                 clk_en_o, locked_o)
// Optional macro CLKDIV_GATE_EN adds bus.clk_gate_i. Each gate is sampled at
// that channel's wrap edge, so gating only ever removes whole periods.
module clk_div_gen_multi #(
  parameter int unsigned NUM_CLK     = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIV_RESET   = 10,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic               board_clk_i,
  input  logic               RESETn_i,
  clk_div_gen_multi_if.slave bus
);

  localparam int unsigned      LCK_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIV_RST_EFF = (DIV_RESET < 2) ? CNT_W'(2) : CNT_W'(DIV_RESET);
  localparam logic [LCK_W-1:0] LOCK_LAST   = LCK_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // Ratios below 2 cannot form a high and a low phase, so they run as 2.
  function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LCK_W-1:0]   r_lock_cnt;
  logic [LCK_W-1:0]   w_lock_nxt;
  logic               r_busy;
  logic               r_locked;
  logic               w_busy_nxt;
  logic               w_locked_nxt;
  logic               w_accept;
  logic               w_all_adopted;

  logic [CNT_W-1:0]   r_cnt  [NUM_CLK];
  logic [CNT_W-1:0]   r_n    [NUM_CLK];
  logic [CNT_W-1:0]   r_pend [NUM_CLK];
  logic [NUM_CLK-1:0] r_adopted;
  logic [NUM_CLK-1:0] r_clk;
  logic [NUM_CLK-1:0] r_en;

  logic [CNT_W-1:0]   w_nxt   [NUM_CLK];
  logic [CNT_W-1:0]   w_n_new [NUM_CLK];
  logic [NUM_CLK-1:0] w_wrap;
  logic [NUM_CLK-1:0] w_adopt;
  logic [NUM_CLK-1:0] w_gate;
  logic [NUM_CLK-1:0] w_clk_d;
  logic [NUM_CLK-1:0] w_en_d;

`ifdef CLKDIV_GATE_EN
  logic [NUM_CLK-1:0] r_gate;
`endif

  // Loads are accepted only when no update is in flight.
  assign w_accept      = bus.div_load_i & ~r_busy;
  assign w_all_adopted = &r_adopted;

  assign bus.div_busy_o = r_busy;
  assign bus.locked_o   = r_locked;
  assign bus.clk_o      = r_clk;
  assign bus.clk_en_o   = r_en;

  // Per-channel counter next value, adoption decision and output next values.
  always_comb begin
    for (int k = 0; k < NUM_CLK; k++) begin
      w_wrap[k]  = (r_cnt[k] == (r_n[k] - CNT_W'(1)));
      w_nxt[k]   = w_wrap[k] ? '0 : (r_cnt[k] + CNT_W'(1));
      w_adopt[k] = w_wrap[k] && (r_state == ST_PENDING) && !r_adopted[k];
      // The adopting edge starts the first full period at the new ratio.
      w_n_new[k] = w_adopt[k] ? r_pend[k] : r_n[k];
`ifdef CLKDIV_GATE_EN
      // Gate value is captured only at the wrap edge so periods stay whole.
      w_gate[k]  = w_wrap[k] ? bus.clk_gate_i[k] : r_gate[k];
`else
      w_gate[k]  = 1'b1;
`endif
      w_clk_d[k] = w_gate[k] & (w_nxt[k] < (w_n_new[k] >> 1));
      w_en_d[k]  = w_gate[k] & (w_nxt[k] == (w_n_new[k] - CNT_W'(1)));
    end
  end

  // Lock/update FSM next-state and registered-output next values.
  always_comb begin
    w_state_nxt  = r_state;
    w_lock_nxt   = r_lock_cnt;
    w_busy_nxt   = 1'b0;
    w_locked_nxt = 1'b0;
    case (r_state)
      ST_LOCKING: begin
        if (w_accept) begin
          w_state_nxt = ST_PENDING;
          w_lock_nxt  = '0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_lock_nxt  = r_lock_cnt + LCK_W'(1);
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          w_state_nxt = ST_PENDING;
          w_lock_nxt  = '0;
        end
      end
      ST_PENDING: begin
        w_lock_nxt = '0;
        if (w_all_adopted) begin
          w_state_nxt = ST_LOCKING;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKING;
        w_lock_nxt  = '0;
      end
    endcase
    w_busy_nxt   = (w_state_nxt == ST_PENDING);
    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  // FSM state, lock counter and status outputs.
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      r_state    <= ST_LOCKING;
      r_lock_cnt <= '0;
      r_busy     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_busy     <= w_busy_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  // Channel counters, active/pending ratios and divided outputs.
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      for (int k = 0; k < NUM_CLK; k++) begin
        r_cnt[k]  <= '0;
        r_n[k]    <= DIV_RST_EFF;
        r_pend[k] <= DIV_RST_EFF;
      end
      r_adopted <= '0;
      r_clk     <= '0;
      r_en      <= '0;
    end else begin
      for (int k = 0; k < NUM_CLK; k++) begin
        r_cnt[k] <= w_nxt[k];
        r_n[k]   <= w_n_new[k];
        if (w_adopt[k]) begin
          r_adopted[k] <= 1'b1;
        end
        if (w_accept) begin
          r_pend[k] <= clamp_ratio(bus.div_i[k*CNT_W +: CNT_W]);
        end
      end
      // A fresh load re-arms adoption on every channel.
      if (w_accept) begin
        r_adopted <= '0;
      end
      r_clk <= w_clk_d;
      r_en  <= w_en_d;
    end
  end

`ifdef CLKDIV_GATE_EN
  // Gate registers: enabled out of reset, updated only on wrap edges.
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      r_gate <= '1;
    end else begin
      r_gate <= w_gate;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_gen_multi.sv
// Directed bench for clk_div_gen_multi (NUM_CLK=2, CNT_W=8, DIV_RESET=10, LOCK_CYCLES=16).
// Expected waveforms are hand-computed per edge, counted from reset release.
// Each per-edge vector is {busy, locked, clk_o[1], clk_o[0], clk_en_o[1], clk_en_o[0]}.
module tb_clk_div_gen_multi;
  localparam int unsigned NUM_CLK = 2;
  localparam int unsigned CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  clk_div_gen_multi_if #(.NUM_CLK(NUM_CLK), .CNT_W(CNT_W)) bus ();

  clk_div_gen_multi #(
    .NUM_CLK(NUM_CLK), .CNT_W(CNT_W), .DIV_RESET(10), .LOCK_CYCLES(16)
  ) dut (
    .board_clk_i(clk),
    .RESETn_i   (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input string s, input int i);
    return s.getc(i) == 8'h31;
  endfunction

  function automatic logic [5:0] obs_vec();
    return {bus.div_busy_o, bus.locked_o, bus.clk_o, bus.clk_en_o};
  endfunction

  // Advance one edge per character and compare the full output vector.
  task automatic seq(input string tag, input string c0, input string c1,
                     input string e0, input string e1, input string bz, input string lk);
    logic [5:0] exp_v;
    for (int i = 0; i < c0.len(); i++) begin
      step();
      exp_v = {bit_at(bz, i), bit_at(lk, i), bit_at(c1, i), bit_at(c0, i),
               bit_at(e1, i), bit_at(e0, i)};
      chk($sformatf("%s@%0d", tag, edge_n), 32'(obs_vec()), 32'(exp_v));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.div_load_i = 1'b0;
    bus.div_i      = '0;
`ifdef CLKDIV_GATE_EN
    bus.clk_gate_i = '1;
`endif
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs_vec()), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;

    // Ratio 10 from reset: first period 4 high, then 5/5; lock on edge 16.
    seq("boot", "11110000011111000001", "11110000011111000001",
        "00000000100000000010", "00000000100000000010",
        "00000000000000000000", "00000000000000011111");

    // Load ch1=3, ch0=4 on edge 40; both adopt at the wrap on edge 50.
    repeat (19) step();
    bus.div_i      = {8'd3, 8'd4};
    bus.div_load_i = 1'b1;
    step();
    bus.div_load_i = 1'b0;
    chk("load_accept@40", 32'(obs_vec()), 32'(6'b101100));
    seq("switch", "1111000001100110011001", "1111000001001001001001",
        "0000000010001000100010", "0000000010010010010010",
        "1111111111000000000000", "0000000000000000000000");
    repeat (4) step();
    chk("relock_pre@66", 32'(bus.locked_o), 32'd0);
    step();
    chk("relock@67", 32'(bus.locked_o), 32'd1);

    // Ratios 0 and 1 clamp to 2; a second load while busy must be ignored.
    repeat (2) step();
    bus.div_i      = {8'd1, 8'd0};
    bus.div_load_i = 1'b1;
    step();
    bus.div_load_i = 1'b0;
    chk("clamp_load@70", 32'(obs_vec()), 32'(6'b100110));
    seq("clamp", "1", "1", "0", "0", "1", "0");
    bus.div_i      = {8'd7, 8'd9};
    bus.div_load_i = 1'b1;
    seq("ignored_load", "0", "0", "0", "1", "1", "0");
    bus.div_load_i = 1'b0;
    seq("clamp_run", "01010101", "10101010", "10101010", "01010101",
        "11000000", "00000000");
    repeat (10) step();
    chk("clamp_lock_pre@90", 32'(bus.locked_o), 32'd0);
    step();
    chk("clamp_lock@91", 32'(bus.locked_o), 32'd1);
    seq("clamp_hold", "1010", "0101", "0101", "1010", "0000", "1111");

    // Reset in the middle of an update discards the pending ratios.
    bus.div_i      = {8'd5, 8'd6};
    bus.div_load_i = 1'b1;
    step();
    bus.div_load_i = 1'b0;
    chk("pend_busy@96", 32'(bus.div_busy_o), 32'd1);
    step();
    chk("pend_busy@97", 32'(bus.div_busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(obs_vec()), 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset", 32'(obs_vec()), 32'd0);
    rst_n  = 1'b1;
    edge_n = 0;
    seq("reboot", "11110000011111000001", "11110000011111000001",
        "00000000100000000010", "00000000100000000010",
        "00000000000000000000", "00000000000000011111");

`ifdef CLKDIV_GATE_EN
    // Ratio 6 on both; gate ch0 off mid-high-phase, then back on.
    bus.div_i      = {8'd6, 8'd6};
    bus.div_load_i = 1'b1;
    step();
    bus.div_load_i = 1'b0;
    repeat (10) step();
    bus.clk_gate_i[0] = 1'b0;
    seq("gate_off", "1000000", "1000111", "0001000", "0001000",
        "0000000", "0000000");
    bus.clk_gate_i[0] = 1'b1;
    seq("gate_on", "000111000", "000111000", "000000001", "001000001",
        "000000000", "000000001");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
